iter_muldiv_unit: RTL

- Multi-cycle multiply/divide responder on the EX-stage start/ready handshake.
- EX raises start_i with operands and stalls until ready_o; this block computes and returns a 64-bit result for HI/LO update.
- Covers mult, multu, div and divu. Multiply is 32-step shift-add; divide is 32-step restoring shift-subtract.
- Sits beside EX. Single instance per core.

---
 rtl/iter_muldiv_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/iter_muldiv_unit.sv
// rtl/iter_muldiv_unit.sv - iterative mult/multu/div/divu responder on the EX start/ready handshake.
// Define MULDIV_FAST_MUL_EN to replace the 32-step multiply with a single-cycle 33x33 product.
module iter_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                sel_mul_div,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   opr;
  logic [2*DATA_W:0]   work;
  logic                is_mul, neg_q, neg_r;
  logic                accept, div_zero;
  logic [DATA_W-1:0]   abs1, abs2;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W+1:0]   trial_diff;
  logic [2*DATA_W-1:0] mul_res;
  logic [DATA_W-1:0]   quo_res, rem_res;
`ifdef MULDIV_FAST_MUL_EN
  logic                       is_signed;
  logic signed [2*DATA_W+1:0] fast_prod;
`endif

  assign accept   = start_i && !annul_i;
  assign div_zero = !sel_mul_div && (opdata2_i == '0);
  assign abs1     = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs2     = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
  assign mul_sum    = {1'b0, work[2*DATA_W-1:DATA_W]} + {1'b0, (work[0] ? opr : '0)};
  // Divide: shifted partial remainder minus divisor; the top bit is the borrow.
  assign trial_diff = work[2*DATA_W:DATA_W-1] - {2'b00, opr};

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod = $signed({is_signed & opr[DATA_W-1], opr})
                   * $signed({is_signed & work[DATA_W-1], work[DATA_W-1:0]});
`endif

  assign mul_res  = neg_q ? -work[2*DATA_W-1:0] : work[2*DATA_W-1:0];
  assign quo_res  = neg_q ? -work[DATA_W-1:0] : work[DATA_W-1:0];
  assign rem_res  = neg_r ? -work[2*DATA_W-1:DATA_W] : work[2*DATA_W-1:DATA_W];
  assign ready_o  = (state == DONE);
  assign result_o = ready_o ? (is_mul ? mul_res : {rem_res, quo_res}) : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = div_zero ? DIVZERO : BUSY;
      DIVZERO: state_nx = annul_i ? IDLE : DONE;
      BUSY: begin
        if (annul_i) state_nx = IDLE;
`ifdef MULDIV_FAST_MUL_EN
        else if (is_mul) state_nx = DONE;
`endif
        else if (cnt == CNT_W'(DATA_W-1)) state_nx = DONE;
      end
      DONE:    if (!start_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      opr    <= '0;
      work   <= '0;
      is_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      is_signed <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt    <= '0;
          is_mul <= sel_mul_div;
          neg_q  <= signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_r  <= signed_i && opdata1_i[DATA_W-1];
          if (sel_mul_div) begin
            opr  <= abs1;
            work <= {{(DATA_W+1){1'b0}}, abs2};
`ifdef MULDIV_FAST_MUL_EN
            // The signed product is already sign-correct, so no final negate.
            is_signed <= signed_i;
            opr       <= opdata1_i;
            work      <= {{(DATA_W+1){1'b0}}, opdata2_i};
            neg_q     <= 1'b0;
`endif
          end else begin
            opr  <= abs2;
            work <= div_zero ? '0 : {{(DATA_W+1){1'b0}}, abs1};
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (is_mul)
`ifdef MULDIV_FAST_MUL_EN
            work <= fast_prod[2*DATA_W:0];
`else
            work <= {1'b0, mul_sum, work[DATA_W-1:1]};
`endif
          else if (!trial_diff[DATA_W+1])
            work <= {trial_diff[DATA_W:0], work[DATA_W-2:0], 1'b1};
          else
            work <= {work[2*DATA_W-1:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

endmodule
